// File: rtl/exp_series_sequencer.sv
// exp_series_sequencer: computes e^x (IEEE-754 binary32) as a truncated Taylor
// series by time-sharing one external add/multiply operator port.
// Each iteration k does term *= x, then term *= 1/k (for k >= 2), then sum += term.
// Optional build macro EXP_SEQ_EARLY_EXIT_EN: stop as soon as the last added
// term can no longer change the running sum.
module exp_series_sequencer #(
  parameter int NUM_TERMS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        s_x_tvalid,
  output logic        s_x_tready,
  input  logic [31:0] s_x_tdata,
  output logic        m_result_tvalid,
  input  logic        m_result_tready,
  output logic [31:0] m_result_tdata,
  output logic        op_tvalid,
  input  logic        op_tready,
  output logic        op_sel,
  output logic [31:0] op_a_tdata,
  output logic [31:0] op_b_tdata,
  input  logic        op_result_tvalid,
  input  logic [31:0] op_result_tdata,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MUL_X     = 3'd1,
    MUL_RECIP = 3'd2,
    ADD       = 3'd3,
    WAIT      = 3'd4,
    DONE      = 3'd5
  } state_t;

  localparam logic [2:0]  K_LAST = 3'(NUM_TERMS - 1);
  localparam logic [31:0] FP_ONE = 32'h3F800000;

  // Reciprocal ROM: 1/k in binary32, correctly rounded.
  function automatic logic [31:0] recip(input logic [2:0] k);
    case (k)
      3'd2:    recip = 32'h3F000000;
      3'd3:    recip = 32'h3EAAAAAB;
      3'd4:    recip = 32'h3E800000;
      3'd5:    recip = 32'h3E4CCCCD;
      3'd6:    recip = 32'h3E2AAAAB;
      3'd7:    recip = 32'h3E124925;
      default: recip = FP_ONE;
    endcase
  endfunction

  state_t      state_r, state_s;
  state_t      ret_r, ret_s;
  logic [31:0] x_r, x_s;
  logic [31:0] term_r, term_s;
  logic [31:0] sum_r, sum_s;
  logic [2:0]  k_r, k_s;
  logic        op_tvalid_r, op_tvalid_s;
  logic        op_sel_r, op_sel_s;
  logic [31:0] op_a_r, op_a_s;
  logic [31:0] op_b_r, op_b_s;
  logic        s_x_tready_r, s_x_tready_s;
  logic        m_tvalid_r, m_tvalid_s;
  logic [31:0] m_tdata_r, m_tdata_s;
  logic        busy_r, busy_s;
  logic        early_exit_s;

`ifdef EXP_SEQ_EARLY_EXIT_EN
  // Term is zero/denormal or more than 24 binades below the new sum.
  assign early_exit_s = (term_r[30:23] == 8'd0) ||
                        (({1'b0, term_r[30:23]} + 9'd24) < {1'b0, op_result_tdata[30:23]});
`else
  assign early_exit_s = 1'b0;
`endif

  assign s_x_tready      = s_x_tready_r;
  assign m_result_tvalid = m_tvalid_r;
  assign m_result_tdata  = m_tdata_r;
  assign op_tvalid       = op_tvalid_r;
  assign op_sel          = op_sel_r;
  assign op_a_tdata      = op_a_r;
  assign op_b_tdata      = op_b_r;
  assign busy            = busy_r;

  // Next-state and next-output logic; every output is registered in the block below.
  always_comb begin
    state_s      = state_r;
    ret_s        = ret_r;
    x_s          = x_r;
    term_s       = term_r;
    sum_s        = sum_r;
    k_s          = k_r;
    op_tvalid_s  = op_tvalid_r;
    op_sel_s     = op_sel_r;
    op_a_s       = op_a_r;
    op_b_s       = op_b_r;
    s_x_tready_s = 1'b0;
    m_tvalid_s   = m_tvalid_r;
    m_tdata_s    = m_tdata_r;
    busy_s       = busy_r;
    case (state_r)
      IDLE: begin
        if (s_x_tvalid && s_x_tready_r) begin
          x_s     = s_x_tdata;
          term_s  = FP_ONE;
          sum_s   = FP_ONE;
          k_s     = 3'd1;
          busy_s  = 1'b1;
          state_s = MUL_X;
        end else begin
          s_x_tready_s = 1'b1;
        end
      end
      MUL_X: begin
        if (!op_tvalid_r) begin
          op_tvalid_s = 1'b1;
          op_sel_s    = 1'b1;
          op_a_s      = term_r;
          op_b_s      = x_r;
        end else if (op_tready) begin
          op_tvalid_s = 1'b0;
          ret_s       = MUL_X;
          state_s     = WAIT;
        end else begin
          op_tvalid_s = 1'b1;
        end
      end
      MUL_RECIP: begin
        if (!op_tvalid_r) begin
          op_tvalid_s = 1'b1;
          op_sel_s    = 1'b1;
          op_a_s      = term_r;
          op_b_s      = recip(k_r);
        end else if (op_tready) begin
          op_tvalid_s = 1'b0;
          ret_s       = MUL_RECIP;
          state_s     = WAIT;
        end else begin
          op_tvalid_s = 1'b1;
        end
      end
      ADD: begin
        if (!op_tvalid_r) begin
          op_tvalid_s = 1'b1;
          op_sel_s    = 1'b0;
          op_a_s      = sum_r;
          op_b_s      = term_r;
        end else if (op_tready) begin
          op_tvalid_s = 1'b0;
          ret_s       = ADD;
          state_s     = WAIT;
        end else begin
          op_tvalid_s = 1'b1;
        end
      end
      WAIT: begin
        if (op_result_tvalid) begin
          case (ret_r)
            MUL_X: begin
              term_s  = op_result_tdata;
              state_s = (k_r >= 3'd2) ? MUL_RECIP : ADD;
            end
            MUL_RECIP: begin
              term_s  = op_result_tdata;
              state_s = ADD;
            end
            ADD: begin
              sum_s = op_result_tdata;
              if ((k_r == K_LAST) || early_exit_s) begin
                m_tvalid_s = 1'b1;
                m_tdata_s  = op_result_tdata;
                state_s    = DONE;
              end else begin
                k_s     = k_r + 3'd1;
                state_s = MUL_X;
              end
            end
            default: begin
              state_s = IDLE;
            end
          endcase
        end else begin
          state_s = WAIT;
        end
      end
      DONE: begin
        if (m_tvalid_r && m_result_tready) begin
          m_tvalid_s   = 1'b0;
          busy_s       = 1'b0;
          s_x_tready_s = 1'b1;
          state_s      = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        op_tvalid_s = 1'b0;
        m_tvalid_s  = 1'b0;
        busy_s      = 1'b0;
        state_s     = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= IDLE;
      ret_r        <= IDLE;
      x_r          <= 32'h00000000;
      term_r       <= FP_ONE;
      sum_r        <= FP_ONE;
      k_r          <= 3'd1;
      op_tvalid_r  <= 1'b0;
      op_sel_r     <= 1'b0;
      op_a_r       <= 32'h00000000;
      op_b_r       <= 32'h00000000;
      s_x_tready_r <= 1'b0;
      m_tvalid_r   <= 1'b0;
      m_tdata_r    <= 32'h00000000;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      ret_r        <= ret_s;
      x_r          <= x_s;
      term_r       <= term_s;
      sum_r        <= sum_s;
      k_r          <= k_s;
      op_tvalid_r  <= op_tvalid_s;
      op_sel_r     <= op_sel_s;
      op_a_r       <= op_a_s;
      op_b_r       <= op_b_s;
      s_x_tready_r <= s_x_tready_s;
      m_tvalid_r   <= m_tvalid_s;
      m_tdata_r    <= m_tdata_s;
      busy_r       <= busy_s;
    end
  end

endmodule

// File: tb/tb_exp_series_sequencer.sv
// Bench for exp_series_sequencer: an operator model answers requests with
// correctly rounded binary32 arithmetic; a reference model computes the series
// directly; a monitor pops expected results from a scoreboard queue.
module tb_exp_series_sequencer;
  localparam int NT = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        s_x_tvalid = 1'b0;
  logic        s_x_tready;
  logic [31:0] s_x_tdata = 32'h0;
  logic        m_result_tvalid;
  logic        m_result_tready = 1'b0;
  logic [31:0] m_result_tdata;
  logic        op_tvalid;
  logic        op_tready = 1'b0;
  logic        op_sel;
  logic [31:0] op_a_tdata, op_b_tdata;
  logic        op_result_tvalid = 1'b0;
  logic [31:0] op_result_tdata = 32'h0;
  logic        busy;

  logic        s2_valid = 1'b0;
  logic        s2_ready;
  logic [31:0] s2_data = 32'h0;
  logic        m2_valid;
  logic        m2_ready = 1'b1;
  logic [31:0] m2_data;
  logic        op2_valid;
  logic        op2_ready = 1'b1;
  logic        op2_sel;
  logic [31:0] op2_a, op2_b;
  logic        op2_rvalid = 1'b0;
  logic [31:0] op2_rdata = 32'h0;
  logic        busy2;

  int checks = 0;
  int failures = 0;

  typedef struct { logic [31:0] data; int ops; int tol; } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  int stall_pct = 0;
  int op_lat = 3;
  bit hold_ready = 1'b0;
  int ops_total = 0;
  int ops_base = 0;
  int cyc = 0;
  bit pend = 1'b0;
  int deliver_at = 0;
  logic [31:0] pend_res = 32'h0;
  bit prev_stall = 1'b0;
  logic prev_sel = 1'b0;
  logic [31:0] prev_a = 32'h0, prev_b = 32'h0;

  int cyc2 = 0;
  int ops2 = 0;
  bit op2_pend = 1'b0;
  int op2_at = 0;
  logic [31:0] op2_res = 32'h0;
  logic [3:0] op2_sels = 4'h0;

  exp_series_sequencer #(.NUM_TERMS(NT)) u_dut (
    .clock(clock), .reset(reset),
    .s_x_tvalid(s_x_tvalid), .s_x_tready(s_x_tready), .s_x_tdata(s_x_tdata),
    .m_result_tvalid(m_result_tvalid), .m_result_tready(m_result_tready),
    .m_result_tdata(m_result_tdata),
    .op_tvalid(op_tvalid), .op_tready(op_tready), .op_sel(op_sel),
    .op_a_tdata(op_a_tdata), .op_b_tdata(op_b_tdata),
    .op_result_tvalid(op_result_tvalid), .op_result_tdata(op_result_tdata),
    .busy(busy)
  );

  exp_series_sequencer #(.NUM_TERMS(2)) u_dut2 (
    .clock(clock), .reset(reset),
    .s_x_tvalid(s2_valid), .s_x_tready(s2_ready), .s_x_tdata(s2_data),
    .m_result_tvalid(m2_valid), .m_result_tready(m2_ready),
    .m_result_tdata(m2_data),
    .op_tvalid(op2_valid), .op_tready(op2_ready), .op_sel(op2_sel),
    .op_a_tdata(op2_a), .op_b_tdata(op2_b),
    .op_result_tvalid(op2_rvalid), .op_result_tdata(op2_rdata),
    .busy(busy2)
  );

  always #5 clock = ~clock;

  // binary32 -> real (denormals flushed; no Inf/NaN in stimulus)
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) d = {f[31], 63'd0};
    else d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  // real -> binary32 with round-to-nearest-even
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [24:0] m;
    logic [28:0] rest;
    int ne;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    m = {2'b01, d[51:29]};
    rest = d[28:0];
    if (rest > 29'h10000000 || (rest == 29'h10000000 && m[0])) m = m + 25'd1;
    ne = int'(d[62:52]) - 896;
    if (m[24]) begin ne = ne + 1; m = m >> 1; end
    if (ne <= 0) return {d[63], 31'd0};
    if (ne >= 255) return {d[63], 8'hFF, 23'd0};
    return {d[63], 8'(ne), m[22:0]};
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) * f2r(b));
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  // Reference: e^x ~ sum_{k=0}^{nt-1} x^k/k!, each step rounded to binary32.
  function automatic void ref_exp(input logic [31:0] x, input int nt,
                                  output logic [31:0] res, output int ops);
    logic [31:0] term, sum;
    term = 32'h3F800000;
    sum  = 32'h3F800000;
    ops  = 0;
    for (int k = 1; k < nt; k++) begin
      term = fmul(term, x);
      ops++;
      if (k >= 2) begin
        term = fmul(term, r2f(1.0 / real'(k)));
        ops++;
      end
      sum = fadd(sum, term);
      ops++;
`ifdef EXP_SEQ_EARLY_EXIT_EN
      if (term[30:23] == 8'd0 || int'(term[30:23]) + 24 < int'(sum[30:23])) break;
`endif
    end
    res = sum;
  endfunction

  function automatic logic [31:0] rand_x();
    logic [31:0] v;
    v[31]    = 1'($urandom_range(0, 1));
    v[30:23] = 8'($urandom_range(118, 128));
    v[22:0]  = 23'($urandom());
    return v;
  endfunction

  task automatic check32(input string name, input logic [31:0] act,
                         input logic [31:0] exp, input int tol);
    logic [31:0] d;
    checks++;
    d = (act > exp) ? act - exp : exp - act;
    if (d > 32'(tol)) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (tol %0d)", name, act, exp, tol);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check32({tag, "_s_x_tready"}, {31'd0, s_x_tready}, 32'd0, 0);
    check32({tag, "_m_tvalid"}, {31'd0, m_result_tvalid}, 32'd0, 0);
    check32({tag, "_m_tdata"}, m_result_tdata, 32'd0, 0);
    check32({tag, "_op_tvalid"}, {31'd0, op_tvalid}, 32'd0, 0);
    check32({tag, "_op_sel"}, {31'd0, op_sel}, 32'd0, 0);
    check32({tag, "_op_a"}, op_a_tdata, 32'd0, 0);
    check32({tag, "_op_b"}, op_b_tdata, 32'd0, 0);
    check32({tag, "_busy"}, {31'd0, busy}, 32'd0, 0);
  endtask

  task automatic send_x(input logic [31:0] x, input logic [31:0] data,
                        input int ops, input int tol);
    int n;
    exp_t e;
    n = 0;
    while (!s_x_tready && n < 2000) begin @(negedge clock); n++; end
    if (!s_x_tready) begin
      checks++;
      failures++;
      $display("FAIL s_x_tready_timeout actual=0 required=1");
    end else begin
      e.data = data; e.ops = ops; e.tol = tol;
      sb_q.push_back(e);
      s_x_tvalid = 1'b1;
      s_x_tdata  = x;
      @(negedge clock);
      s_x_tvalid = 1'b0;
      s_x_tdata  = $urandom();
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (n < 3000 && (sb_q.size() != 0 || !s_x_tready || busy)) begin
      @(negedge clock);
      n++;
    end
    check32("idle_reached", {31'd0, (sb_q.size() == 0 && s_x_tready && !busy)}, 32'd1, 0);
  endtask

  // Operator model for the main DUT: random stalls, configurable latency.
  always @(negedge clock) begin
    cyc++;
    if (pend && cyc == deliver_at) begin
      op_result_tvalid = 1'b1;
      op_result_tdata  = pend_res;
      pend = 1'b0;
    end else begin
      op_result_tvalid = 1'b0;
      op_result_tdata  = $urandom();
    end
    if (!reset && prev_stall) begin
      check32("stall_valid_held", {31'd0, op_tvalid}, 32'd1, 0);
      check32("stall_sel_held", {31'd0, op_sel}, {31'd0, prev_sel}, 0);
      check32("stall_a_held", op_a_tdata, prev_a, 0);
      check32("stall_b_held", op_b_tdata, prev_b, 0);
    end
    prev_stall = 1'b0;
    op_tready = ($urandom_range(0, 99) >= stall_pct);
    if (!reset && op_tvalid) begin
      if (op_tready) begin
        check32("one_outstanding", {31'd0, pend}, 32'd0, 0);
        pend_res   = op_sel ? fmul(op_a_tdata, op_b_tdata) : fadd(op_a_tdata, op_b_tdata);
        pend       = 1'b1;
        deliver_at = cyc + ((op_lat == 0) ? int'($urandom_range(1, 4)) : op_lat);
        ops_total++;
      end else begin
        prev_stall = 1'b1;
        prev_sel   = op_sel;
        prev_a     = op_a_tdata;
        prev_b     = op_b_tdata;
      end
    end
  end

  // Operator model for the two-term DUT: always ready, latency 2.
  always @(negedge clock) begin
    cyc2++;
    if (op2_pend && cyc2 == op2_at) begin
      op2_rvalid = 1'b1;
      op2_rdata  = op2_res;
      op2_pend   = 1'b0;
    end else begin
      op2_rvalid = 1'b0;
      op2_rdata  = $urandom();
    end
    if (!reset && op2_valid && op2_ready) begin
      op2_sels = {op2_sels[2:0], op2_sel};
      ops2++;
      op2_res  = op2_sel ? fmul(op2_a, op2_b) : fadd(op2_a, op2_b);
      op2_pend = 1'b1;
      op2_at   = cyc2 + 2;
    end
  end

  // Result monitor: drives m_result_tready and checks each completed result.
  always @(negedge clock) begin
    if (reset) begin
      sb_q.delete();
      ops_base = ops_total;
    end
    m_result_tready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    if (!reset && m_result_tvalid && m_result_tready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=%h required=none", m_result_tdata);
      end else begin
        mon_e = sb_q.pop_front();
        check32("result", m_result_tdata, mon_e.data, mon_e.tol);
        check32("op_count", ops_total - ops_base, mon_e.ops, 0);
        check32("busy_at_result", {31'd0, busy}, 32'd1, 0);
      end
      ops_base = ops_total;
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] xr, held, mres;
    int mops, t0, n;
    repeat (3) @(negedge clock);
    check_reset_vals("rst");
    reset = 1'b0;
    @(negedge clock);
    check32("tready_after_reset", {31'd0, s_x_tready}, 32'd1, 0);

    // -0.25 with fixed latency 3
    op_lat = 3; stall_pct = 0;
    send_x(32'hBE800000, 32'h3F475555, 2 + 3 * (NT - 2), 1);
    wait_idle();
    check32("busy_low_after", {31'd0, busy}, 32'd0, 0);

    // x = 0
`ifdef EXP_SEQ_EARLY_EXIT_EN
    send_x(32'h00000000, 32'h3F800000, 2, 0);
`else
    send_x(32'h00000000, 32'h3F800000, 2 + 3 * (NT - 2), 0);
`endif
    wait_idle();

    // 0.5 with heavy operator stalls
    stall_pct = 50; op_lat = 0;
    send_x(32'h3F000000, 32'h3FD2AAAB, 2 + 3 * (NT - 2), 1);
    wait_idle();
    stall_pct = 0; op_lat = 3;

    // downstream back-pressure for 20 cycles
    hold_ready = 1'b1;
    xr = rand_x();
    ref_exp(xr, NT, mres, mops);
    send_x(xr, mres, mops, 0);
    n = 0;
    while (!m_result_tvalid && n < 2000) begin @(negedge clock); n++; end
    check32("hold_seen_valid", {31'd0, m_result_tvalid}, 32'd1, 0);
    held = m_result_tdata;
    t0 = ops_total;
    repeat (20) begin
      @(negedge clock);
      check32("hold_valid", {31'd0, m_result_tvalid}, 32'd1, 0);
      check32("hold_data", m_result_tdata, held, 0);
      check32("hold_s_x_tready", {31'd0, s_x_tready}, 32'd0, 0);
      check32("hold_no_op", {31'd0, op_tvalid}, 32'd0, 0);
    end
    check32("hold_op_count", ops_total - t0, 32'd0, 0);
    hold_ready = 1'b0;
    wait_idle();

    // reset while waiting on the 5th operation, then a stray late result
    t0 = ops_total;
    send_x(32'hBE800000, 32'h3F475555, 2 + 3 * (NT - 2), 1);
    n = 0;
    while (ops_total - t0 < 5 && n < 2000) begin @(negedge clock); #1; n++; end
    check32("fifth_op_reached", ops_total - t0, 32'd5, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_reset_vals("mid_rst");
    reset = 1'b0;
    @(negedge clock);
    check32("mid_rst_tready", {31'd0, s_x_tready}, 32'd1, 0);
    @(negedge clock);
    check32("stray_op_tvalid", {31'd0, op_tvalid}, 32'd0, 0);
    check32("stray_busy", {31'd0, busy}, 32'd0, 0);
    check32("stray_s_x_tready", {31'd0, s_x_tready}, 32'd1, 0);
    check32("stray_m_tvalid", {31'd0, m_result_tvalid}, 32'd0, 0);
    repeat (4) @(negedge clock);
    send_x(32'hBE800000, 32'h3F475555, 2 + 3 * (NT - 2), 1);
    wait_idle();

    // two-term instance: 1 + x with x = 1.0
    n = 0;
    while (!s2_ready && n < 100) begin @(negedge clock); n++; end
    s2_valid = 1'b1;
    s2_data  = 32'h3F800000;
    @(negedge clock);
    s2_valid = 1'b0;
    n = 0;
    while (!m2_valid && n < 500) begin @(negedge clock); n++; end
    check32("nt2_result", m2_data, 32'h40000000, 0);
    check32("nt2_op_count", ops2, 32'd2, 0);
    check32("nt2_op_order", {30'd0, op2_sels[1:0]}, 32'd2, 0);
    @(negedge clock);
    check32("nt2_valid_drop", {31'd0, m2_valid}, 32'd0, 0);

    // random operands, stalls and latencies, back to back
    stall_pct = 25; op_lat = 0;
    for (int i = 0; i < 30; i++) begin
      xr = rand_x();
      ref_exp(xr, NT, mres, mops);
      send_x(xr, mres, mops, 0);
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exp_series_sequencer.md
# exp_series_sequencer

Controller that computes e^x in IEEE-754 single precision by sequencing one shared floating-point operator (multiply or add, one request outstanding) through a truncated Taylor series. It accepts x on a valid/ready input and returns e^x on a valid/ready output. It replaces the per-term fixed operator chain with one time-shared operator port, trading latency for area.

## Interface
- NUM_TERMS, 4, number of series terms including the constant 1.0; legal range 2..8.
- clock  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; clears FSM and all outputs.
- s_x_tvalid  in  1  input x valid.
- s_x_tready  out  1  sequencer can accept x (IDLE only).
- s_x_tdata  in  32  x, binary32.
- m_result_tvalid  out  1  e^x valid.
- m_result_tready  in  1  downstream accepts result.
- m_result_tdata  out  32  e^x, binary32.
- op_tvalid  out  1  operator request valid.
- op_tready  in  1  operator accepts request.
- op_sel  out  1  0 = add, 1 = multiply.
- op_a_tdata  out  32  operand A.
- op_b_tdata  out  32  operand B.
- op_result_tvalid  in  1  operator result valid (one pulse per accepted request; always accepted).
- op_result_tdata  in  32  operator result.
- busy  out  1  high from x acceptance until result handshake completes.

## Operation
- Registers: x_reg, term (init 0x3F800000), sum (init 0x3F800000), k (3-bit, init 1).
- Reciprocal ROM (index k): 1/2=0x3F000000, 1/3=0x3EAAAAAB, 1/4=0x3E800000, 1/5=0x3E4CCCCD, 1/6=0x3E2AAAAB, 1/7=0x3E124925.
- FSM states: IDLE, MUL_X, MUL_RECIP, ADD, WAIT, DONE.
- IDLE: s_x_tready=1; on s_x_tvalid capture x_reg, reset term/sum/k, go MUL_X.
- MUL_X: request term*x_reg (op_sel=1); WAIT; result -> term; if k>=2 go MUL_RECIP else ADD.
- MUL_RECIP: request term*recip(k); WAIT; result -> term; go ADD.
- ADD: request sum+term (op_sel=0); WAIT; result -> sum; if k==NUM_TERMS-1 go DONE, else k<=k+1, go MUL_X.
- WAIT: holds a return-state register; leaves on op_result_tvalid.
- DONE: m_result_tvalid=1, m_result_tdata=sum; on m_result_tready go IDLE.
- Operation count per x: 2 + 3*(NUM_TERMS-2); NUM_TERMS=4 gives 8.
- NUM_TERMS=2: single MUL_X (term=x) then ADD; result = 1+x.
- No NaN/Inf special-casing; operator results propagate unchanged.
- op_result_tvalid outside WAIT is ignored (no state change).

## Timing
- Reset values: s_x_tready=0 during reset, 1 first cycle after; m_result_tvalid=0, m_result_tdata=0, op_tvalid=0, op_sel=0, op_a_tdata=0, op_b_tdata=0, busy=0.
- op_tvalid registered, asserted the cycle after entering a request state; op_sel/op_a_tdata/op_b_tdata stable while op_tvalid=1 && op_tready=0; op_tvalid drops the cycle after handshake.
- Exactly one request outstanding; no new op_tvalid until op_result_tvalid received.
- Total latency (x accept to m_result_tvalid) = sum over ops of (1 + op_tready stall + operator latency + 1) + 1 cycles.
- m_result_tvalid/m_result_tdata held until m_result_tready; s_x_tready=0 until DONE handshake completes (next acceptance earliest one cycle after).
- Reset asserted mid-sequence: next cycle IDLE, all outputs at reset values; a late op_result_tvalid is ignored.

## Configuration
- EXP_SEQ_EARLY_EXIT_EN defined: after each ADD, if term exponent field is 0 or term exponent + 24 < sum exponent, go DONE immediately (term no longer affects sum).
- Undefined: always run all NUM_TERMS-1 iterations; op count fixed by formula above.

## Test plan
- x=0xBE800000 (-0.25), NUM_TERMS=4, zero-latency-plus-3 operator model -> 8 ops issued, m_result_tdata=0x3F475555 (±1 ulp), busy low after handshake.
- x=0x00000000, NUM_TERMS=4 -> result 0x3F800000; 8 ops without EXP_SEQ_EARLY_EXIT_EN, 2 ops with it.
- Random op_tready stalls (50%) on x=0x3F000000 -> operands stable during stalls, result 0x3FD2AAAB (1+0.5+0.125+0.0208333, ±1 ulp).
- m_result_tready held low 20 cycles -> m_result_tvalid/data held, s_x_tready=0 throughout, no ops issued.
- reset pulsed during WAIT of 5th op, then stray op_result_tvalid -> outputs at reset values, FSM IDLE, next x=0xBE800000 yields 0x3F475555.
- NUM_TERMS=2, x=0x3F800000 -> 2 ops (mul then add), result 0x40000000.
